// File: rtl/irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : irq_sequencer
// Description : Four-input prioritised interrupt sequencer with a register
//               file for mask/pending/in-service/control/vector base.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sequencer #(
  parameter logic [7:0] BASE_ADDRESS = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  din,
  input  logic [7:0]  address,
  input  logic        w_en,
  input  logic        r_en,
  output logic [7:0]  dout,
  input  logic [3:0]  irq,
  output logic        interrupt,
  output logic [15:0] intVect,
  input  logic        intAck
);

  localparam logic [2:0] C_OFF_MASK  = 3'd0;
  localparam logic [2:0] C_OFF_PEND  = 3'd1;
  localparam logic [2:0] C_OFF_INSV  = 3'd2;
  localparam logic [2:0] C_OFF_CTRL  = 3'd3;
  localparam logic [2:0] C_OFF_EOI   = 3'd4;
  localparam logic [2:0] C_OFF_VBL   = 3'd5;
  localparam logic [2:0] C_OFF_VBH   = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ACKED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_mask;
  logic [3:0]  r_pend;
  logic [3:0]  r_insv;
  logic [2:0]  r_ctrl;
  logic [7:0]  r_vbase_l;
  logic [7:0]  r_vbase_h;
  logic [1:0]  r_rot_ptr;
  logic [3:0]  r_irq_prev;
  logic [1:0]  r_cur_id;
  logic        r_interrupt;
  logic [15:0] r_int_vect;
  logic [7:0]  r_dout;

  logic [7:0]  w_off;
  logic        w_mapped;
  logic        w_wr;
  logic        w_wr_mask;
  logic        w_wr_pend;
  logic        w_wr_ctrl;
  logic        w_wr_eoi;
  logic        w_wr_vbl;
  logic        w_wr_vbh;
  logic [1:0]  w_base;
  logic [3:0]  w_elig;
  logic        w_sel_valid;
  logic [1:0]  w_sel_id;
  logic        w_eoi_valid;
  logic [1:0]  w_eoi_id;
  logic        w_eoi;
  logic        w_take;
  logic        w_ack;
  logic [3:0]  w_ack_mask;
  logic [3:0]  w_eoi_mask;
  logic [3:0]  w_pend_wclr;
  logic [3:0]  w_edge;
  logic [15:0] w_vect_new;

  // Position of an id in the current priority order (0 = highest).
  function automatic logic [1:0] f_rank(input logic [1:0] id, input logic [1:0] base);
    return id - base;
  endfunction

  assign w_off     = address - BASE_ADDRESS;
  assign w_mapped  = (w_off < 8'd7);
  assign w_wr      = w_en & w_mapped;
  assign w_wr_mask = w_wr & (w_off[2:0] == C_OFF_MASK);
  assign w_wr_pend = w_wr & (w_off[2:0] == C_OFF_PEND);
  assign w_wr_ctrl = w_wr & (w_off[2:0] == C_OFF_CTRL);
  assign w_wr_eoi  = w_wr & (w_off[2:0] == C_OFF_EOI);
  assign w_wr_vbl  = w_wr & (w_off[2:0] == C_OFF_VBL);
  assign w_wr_vbh  = w_wr & (w_off[2:0] == C_OFF_VBH);

  assign w_base = r_ctrl[1] ? r_rot_ptr : 2'd0;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_elig[n] = r_pend[n] & ~r_mask[n] & r_ctrl[0];
      for (int m = 0; m < 4; m++) begin
        if (r_insv[m] && (f_rank(2'(n), w_base) >= f_rank(2'(m), w_base)))
          w_elig[n] = 1'b0;
      end
    end
  end

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_id    = 2'd0;
    w_eoi_valid = 1'b0;
    w_eoi_id    = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (w_elig[2'(w_base + 2'(r))]) begin
        w_sel_valid = 1'b1;
        w_sel_id    = 2'(w_base + 2'(r));
      end
      if (r_insv[2'(w_base + 2'(r))]) begin
        w_eoi_valid = 1'b1;
        w_eoi_id    = 2'(w_base + 2'(r));
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sel_valid) begin
          w_state_nxt = S_REQ;
          w_take      = 1'b1;
        end
      end
      S_REQ: begin
        if (intAck) begin
          w_state_nxt = S_ACKED;
          w_ack       = 1'b1;
        end else if (!w_elig[r_cur_id]) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACKED: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_eoi       = w_wr_eoi & w_eoi_valid;
  assign w_ack_mask  = w_ack ? (4'b0001 << r_cur_id) : 4'b0000;
  assign w_eoi_mask  = w_eoi ? (4'b0001 << w_eoi_id) : 4'b0000;
  assign w_pend_wclr = w_wr_pend ? din[3:0] : 4'b0000;
  assign w_edge      = irq & ~r_irq_prev;
  assign w_vect_new  = {r_vbase_h, r_vbase_l} + {12'b0, w_sel_id, 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cur_id    <= 2'd0;
      r_interrupt <= 1'b0;
      r_int_vect  <= 16'h0000;
    end else begin
      r_state     <= w_state_nxt;
      r_interrupt <= (w_state_nxt == S_REQ);
      if (w_take) begin
        r_cur_id   <= w_sel_id;
        r_int_vect <= w_vect_new;
      end else if (w_state_nxt != S_REQ) begin
        r_int_vect <= 16'h0000;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask     <= 4'hF;
      r_pend     <= 4'h0;
      r_insv     <= 4'h0;
      r_ctrl     <= 3'd0;
      r_vbase_l  <= 8'h00;
      r_vbase_h  <= 8'h00;
      r_rot_ptr  <= 2'd0;
      r_irq_prev <= 4'h0;
    end else begin
      r_irq_prev <= irq;
      if (w_wr_mask) r_mask    <= din[3:0];
      if (w_wr_ctrl) r_ctrl    <= din[2:0];
      if (w_wr_vbl)  r_vbase_l <= din;
      if (w_wr_vbh)  r_vbase_h <= din;
      // New edges take precedence over any clear landing on the same clock.
      if (r_ctrl[2])
        r_pend <= (r_pend & ~(w_pend_wclr | w_ack_mask)) | w_edge;
      else
        r_pend <= irq;
      r_insv <= (r_insv & ~w_eoi_mask) | w_ack_mask;
      if (w_eoi && r_ctrl[1])
        r_rot_ptr <= w_eoi_id + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout <= 8'h00;
    end else if (r_en && w_mapped) begin
      case (w_off[2:0])
        C_OFF_MASK: r_dout <= {4'h0, r_mask};
        C_OFF_PEND: r_dout <= {4'h0, r_pend};
        C_OFF_INSV: r_dout <= {4'h0, r_insv};
        C_OFF_CTRL: r_dout <= {5'h00, r_ctrl};
        C_OFF_VBL:  r_dout <= r_vbase_l;
        C_OFF_VBH:  r_dout <= r_vbase_h;
        default:    r_dout <= 8'h00;
      endcase
    end else begin
      r_dout <= 8'h00;
    end
  end

  assign dout      = r_dout;
  assign interrupt = r_interrupt;
  assign intVect   = r_int_vect;

endmodule
`default_nettype wire

// File: tb/tb_irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_sequencer
// Description : Scoreboard bench for irq_sequencer (register reads queued and
//               compared one clock later; interrupt/vector checked directly).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_sequencer;

  localparam logic [7:0] C_B = 8'h10;
  localparam logic [7:0] C_MASK = C_B + 8'd0;
  localparam logic [7:0] C_PEND = C_B + 8'd1;
  localparam logic [7:0] C_INSV = C_B + 8'd2;
  localparam logic [7:0] C_CTRL = C_B + 8'd3;
  localparam logic [7:0] C_EOI  = C_B + 8'd4;
  localparam logic [7:0] C_VBL  = C_B + 8'd5;
  localparam logic [7:0] C_VBH  = C_B + 8'd6;

  logic        clk;
  logic        reset;
  logic [7:0]  din;
  logic [7:0]  address;
  logic        w_en;
  logic        r_en;
  logic [7:0]  dout;
  logic [3:0]  irq;
  logic        interrupt;
  logic [15:0] intVect;
  logic        intAck;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } rd_t;

  rd_t  q[$];
  rd_t  mon_e;
  logic rd_seen = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  irq_sequencer #(.BASE_ADDRESS(C_B)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .address   (address),
    .w_en      (w_en),
    .r_en      (r_en),
    .dout      (dout),
    .irq       (irq),
    .interrupt (interrupt),
    .intVect   (intVect),
    .intAck    (intAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) rd_seen <= r_en;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (q.size() == 0) begin
        check("sb_underflow", 16'd1, 16'd0);
      end else begin
        mon_e = q.pop_front();
        check(mon_e.tag, {8'h00, dout}, {8'h00, mon_e.exp});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    address = a; din = d; w_en = 1'b1;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string tag);
    rd_t x;
    x.tag = tag; x.exp = e;
    q.push_back(x);
    address = a; r_en = 1'b1;
    @(negedge clk);
    r_en = 1'b0;
  endtask

  task automatic ack();
    intAck = 1'b1;
    @(negedge clk);
    intAck = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; din = 8'h00; address = 8'h00; w_en = 1'b0;
    r_en = 1'b0; irq = 4'h0; intAck = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_int", {15'h0, interrupt}, 16'h0);
    check("rst_vect", intVect, 16'h0000);
    check("rst_dout", {8'h00, dout}, 16'h0000);
    reset = 1'b1;
    idle(1);
    rd(C_MASK, 8'h0F, "rst_mask");
    rd(C_PEND, 8'h00, "rst_pend");
    rd(C_CTRL, 8'h00, "rst_ctrl");
    wr(C_INSV, 8'h0F);
    rd(C_INSV, 8'h00, "insv_ro");
    wr(8'h17, 8'hAA);
    wr(C_VBL, 8'h5A);
    rd(C_VBL, 8'h5A, "vbl_rw");
    rd(8'h17, 8'h00, "unmapped_rd");
    rd(C_EOI, 8'h00, "eoi_rd");

    // Basic edge request, ack
    wr(C_VBH, 8'h01); wr(C_VBL, 8'h00); wr(C_MASK, 8'h00); wr(C_CTRL, 8'h05);
    rd(C_CTRL, 8'h05, "ctrl_rw");
    rd(C_VBH, 8'h01, "vbh_rw");
    irq = 4'b0100; idle(1); irq = 4'b0000;
    check("t1_int_early", {15'h0, interrupt}, 16'h0);
    rd(C_PEND, 8'h04, "t1_pend");
    check("t1_int", {15'h0, interrupt}, 16'h1);
    check("t1_vect", intVect, 16'h0108);
    ack();
    check("t1_int_ack", {15'h0, interrupt}, 16'h0);
    rd(C_INSV, 8'h04, "t1_insv");
    rd(C_PEND, 8'h00, "t1_pend_clr");

    // Nesting
    irq = 4'b1000; idle(3);
    check("t2_no_int", {15'h0, interrupt}, 16'h0);
    rd(C_PEND, 8'h08, "t2_pend3");
    irq = 4'b1010; idle(2);
    check("t2_int", {15'h0, interrupt}, 16'h1);
    check("t2_vect", intVect, 16'h0104);
    ack(); irq = 4'b0000;
    rd(C_INSV, 8'h06, "t2_insv");
    wr(C_EOI, 8'h00);
    rd(C_INSV, 8'h04, "t2_eoi1");
    check("t2_still_blocked", {15'h0, interrupt}, 16'h0);
    wr(C_EOI, 8'h00);
    rd(C_INSV, 8'h00, "t2_eoi2");
    check("t2_int3", {15'h0, interrupt}, 16'h1);
    check("t2_vect3", intVect, 16'h010C);
    ack(); wr(C_EOI, 8'h00);
    rd(C_INSV, 8'h00, "t2_insv_end");
    rd(C_PEND, 8'h00, "t2_pend_end");

    // Rotate
    wr(C_CTRL, 8'h07);
    irq = 4'b0001; idle(1); irq = 4'b0000; idle(1);
    check("t3_vect0", intVect, 16'h0100);
    ack(); wr(C_EOI, 8'h00);
    irq = 4'b1001; idle(1); irq = 4'b0000; idle(1);
    check("t3_int", {15'h0, interrupt}, 16'h1);
    check("t3_rot_pick", intVect, 16'h010C);
    ack(); idle(2);
    check("t3_no_nest", {15'h0, interrupt}, 16'h0);
    wr(C_EOI, 8'h00); idle(1);
    check("t3_int0", {15'h0, interrupt}, 16'h1);
    check("t3_vect0b", intVect, 16'h0100);
    ack(); wr(C_EOI, 8'h00);
    rd(C_INSV, 8'h00, "t3_insv_end");
    rd(C_PEND, 8'h00, "t3_pend_end");

    // Mask during REQ
    wr(C_CTRL, 8'h05);
    irq = 4'b0100; idle(1); irq = 4'b0000; idle(1);
    check("t4_vect", intVect, 16'h0108);
    wr(C_MASK, 8'h04); idle(1);
    check("t4_masked", {15'h0, interrupt}, 16'h0);
    rd(C_PEND, 8'h04, "t4_pend_kept");
    wr(C_MASK, 8'h00); idle(1);
    check("t4_rereq", {15'h0, interrupt}, 16'h1);
    check("t4_rereq_vect", intVect, 16'h0108);
    ack(); wr(C_EOI, 8'h00);
    rd(C_INSV, 8'h00, "t4_insv_end");

    // Set beats clear; EOI with nothing in service; W1C; stray ack
    irq = 4'b0010; wr(C_PEND, 8'h02); irq = 4'b0000;
    rd(C_PEND, 8'h02, "t5_set_wins");
    ack(); wr(C_EOI, 8'h00);
    wr(C_EOI, 8'h00);
    rd(C_MASK, 8'h00, "t5_eoi0_mask");
    rd(C_PEND, 8'h00, "t5_eoi0_pend");
    rd(C_INSV, 8'h00, "t5_eoi0_insv");
    rd(C_CTRL, 8'h05, "t5_eoi0_ctrl");
    wr(C_MASK, 8'h0F);
    irq = 4'b1000; idle(1); irq = 4'b0000;
    rd(C_PEND, 8'h08, "t5_pend_masked");
    wr(C_PEND, 8'h08);
    rd(C_PEND, 8'h00, "t5_w1c");
    ack();
    rd(C_INSV, 8'h00, "t5_stray_ack");

    // Level mode and vector wrap
    wr(C_VBH, 8'hFF); wr(C_VBL, 8'hFC); wr(C_CTRL, 8'h01);
    irq = 4'b0101; idle(1);
    rd(C_PEND, 8'h05, "t6_level");
    wr(C_PEND, 8'h0F);
    rd(C_PEND, 8'h05, "t6_level_nowr");
    wr(C_MASK, 8'h07);
    irq = 4'b1000; idle(2);
    check("t6_int", {15'h0, interrupt}, 16'h1);
    check("t6_wrap", intVect, 16'h0008);
    irq = 4'b0000; idle(2);
    check("t6_level_drop", {15'h0, interrupt}, 16'h0);

    // Asynchronous reset during REQ
    wr(C_CTRL, 8'h05); wr(C_MASK, 8'h00);
    irq = 4'b0001; idle(1); irq = 4'b0000; idle(1);
    check("t7_pre", {15'h0, interrupt}, 16'h1);
    #2 reset = 1'b0;
    #1;
    check("t7_async_int", {15'h0, interrupt}, 16'h0);
    check("t7_async_vect", intVect, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    rd(C_MASK, 8'h0F, "t7_mask");
    rd(C_PEND, 8'h00, "t7_pend");
    rd(C_INSV, 8'h00, "t7_insv");
    rd(C_CTRL, 8'h00, "t7_ctrl");
    rd(C_VBL, 8'h00, "t7_vbl");
    rd(C_VBH, 8'h00, "t7_vbh");
    check("t7_int_after", {15'h0, interrupt}, 16'h0);

    idle(2);
    check("sb_empty", 16'(q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
